// File: rtl/branch_ctrl.sv
// Branch resolution controller.
// Resolves conditional BR instructions against forwarded or architectural
// condition codes. Holds the front end while the CC source is not yet
// available, then redirects the PC and squashes IF/ID on a taken branch.
// Also keeps saturating counts of resolved and taken branches.
//
// Ports:
//   clk, rst_n        clock; synchronous active-low reset
//   br_valid          BR instruction present in resolve stage
//   br_nzp            branch nzp mask (bit2=n, bit1=z, bit0=p)
//   br_target         branch target address
//   cc_valid, cc      architectural CC and its validity
//   cc_fwd_valid, cc_fwd  forwarded CC from an in-flight producer
//   mem_stall         pipeline frozen by the memory stage
//   stall_front       hold fetch/decode/resolve stages
//   pc_redirect       load PC from redirect_pc
//   redirect_pc       taken-branch target (0 when not redirecting)
//   flush_if, flush_id  squash IF and ID pipeline registers
//   br_count, taken_count  saturating resolved/taken branch counters
module branch_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        br_valid,
  input  logic [2:0]  br_nzp,
  input  logic [15:0] br_target,
  input  logic        cc_valid,
  input  logic [2:0]  cc,
  input  logic        cc_fwd_valid,
  input  logic [2:0]  cc_fwd,
  input  logic        mem_stall,
  output logic        stall_front,
  output logic        pc_redirect,
  output logic [15:0] redirect_pc,
  output logic        flush_if,
  output logic        flush_id,
  output logic [15:0] br_count,
  output logic [15:0] taken_count
);

  localparam int unsigned AW = 16;
  localparam int unsigned CW = 16;
  localparam logic [CW-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_CC  = 2'd1,
    REDIRECT = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [2:0]    nzp_q, nzp_nxt;
  logic [AW-1:0] tgt_q, tgt_nxt;
  logic [CW-1:0] br_cnt_q, tk_cnt_q;

  logic       cc_avail;
  logic [2:0] cc_src;
  logic       resolve, take, stall;

  // CC source select: forwarded value wins over the architectural register.
  always_comb begin
    cc_avail = cc_fwd_valid | cc_valid;
    cc_src   = 3'b000;
    if (cc_fwd_valid) cc_src = cc_fwd;
    else if (cc_valid) cc_src = cc;
  end

  function automatic logic is_taken(input logic [2:0] nzp, input logic [2:0] src);
    return (nzp == 3'b111) | (|(nzp & src));
  endfunction

  // State and latched-branch registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      nzp_q <= 3'b000;
      tgt_q <= '0;
    end else begin
      state <= state_nxt;
      nzp_q <= nzp_nxt;
      tgt_q <= tgt_nxt;
    end
  end

  // Next-state, latch and resolution decode.
  always_comb begin
    state_nxt = state;
    nzp_nxt   = nzp_q;
    tgt_nxt   = tgt_q;
    resolve   = 1'b0;
    take      = 1'b0;
    stall     = 1'b0;
    unique case (state)
      IDLE: begin
        if (br_valid && !mem_stall) begin
          // Unconditional BR needs no CC, so it resolves even without a source.
          if (cc_avail || br_nzp == 3'b111) begin
            resolve = 1'b1;
            take    = is_taken(br_nzp, cc_src);
            if (take) begin
              tgt_nxt   = br_target;
              state_nxt = REDIRECT;
            end
          end else begin
            nzp_nxt   = br_nzp;
            tgt_nxt   = br_target;
            stall     = 1'b1;
            state_nxt = WAIT_CC;
          end
        end
      end
      WAIT_CC: begin
        stall = 1'b1;
        if (!mem_stall && (cc_avail || nzp_q == 3'b111)) begin
          resolve   = 1'b1;
          take      = is_taken(nzp_q, cc_src);
          state_nxt = take ? REDIRECT : IDLE;
        end
      end
      REDIRECT: begin
        if (!mem_stall) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Saturating branch statistics, updated on the resolving edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      br_cnt_q <= '0;
      tk_cnt_q <= '0;
    end else begin
      if (resolve && br_cnt_q != CNT_MAX) br_cnt_q <= br_cnt_q + CW'(1);
      if (take && tk_cnt_q != CNT_MAX)    tk_cnt_q <= tk_cnt_q + CW'(1);
    end
  end

  // Outputs are forced low while reset is asserted so an aborted
  // WAIT_CC/REDIRECT never leaks a stall or redirect.
  always_comb begin
    stall_front = rst_n & stall;
    pc_redirect = rst_n & (state == REDIRECT);
    flush_if    = pc_redirect;
    flush_id    = pc_redirect;
    redirect_pc = pc_redirect ? tgt_q : '0;
    br_count    = rst_n ? br_cnt_q : '0;
    taken_count = rst_n ? tk_cnt_q : '0;
  end

endmodule

// File: tb/tb_branch_ctrl.sv
// Directed self-checking bench for branch_ctrl.
module tb_branch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        br_valid;
  logic [2:0]  br_nzp;
  logic [15:0] br_target;
  logic        cc_valid;
  logic [2:0]  cc;
  logic        cc_fwd_valid;
  logic [2:0]  cc_fwd;
  logic        mem_stall;
  logic        stall_front;
  logic        pc_redirect;
  logic [15:0] redirect_pc;
  logic        flush_if;
  logic        flush_id;
  logic [15:0] br_count;
  logic [15:0] taken_count;

  int n_cmp = 0;
  int n_bad = 0;

  branch_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .br_valid     (br_valid),
    .br_nzp       (br_nzp),
    .br_target    (br_target),
    .cc_valid     (cc_valid),
    .cc           (cc),
    .cc_fwd_valid (cc_fwd_valid),
    .cc_fwd       (cc_fwd),
    .mem_stall    (mem_stall),
    .stall_front  (stall_front),
    .pc_redirect  (pc_redirect),
    .redirect_pc  (redirect_pc),
    .flush_if     (flush_if),
    .flush_id     (flush_id),
    .br_count     (br_count),
    .taken_count  (taken_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are then observed 1 time unit after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_redir(input string tag, input logic exp_pc, input logic [15:0] exp_tgt);
    chk({tag, ".pc_redirect"}, 32'(pc_redirect), 32'(exp_pc));
    chk({tag, ".flush_if"},    32'(flush_if),    32'(exp_pc));
    chk({tag, ".flush_id"},    32'(flush_id),    32'(exp_pc));
    chk({tag, ".redirect_pc"}, 32'(redirect_pc), 32'(exp_tgt));
  endtask

  task automatic chk_cnt(input string tag, input logic [15:0] exp_br, input logic [15:0] exp_tk);
    chk({tag, ".br_count"},    32'(br_count),    32'(exp_br));
    chk({tag, ".taken_count"}, 32'(taken_count), 32'(exp_tk));
  endtask

  initial begin
    rst_n = 1'b0; br_valid = 1'b0; br_nzp = 3'b000; br_target = 16'h0000;
    cc_valid = 1'b0; cc = 3'b000; cc_fwd_valid = 1'b0; cc_fwd = 3'b000; mem_stall = 1'b0;

    // Reset: outputs low during and in the cycle after reset.
    #1;
    chk("rst.stall", 32'(stall_front), 32'd0);
    cyc(); cyc();
    chk_redir("rst", 1'b0, 16'h0000);
    chk_cnt("rst", 16'd0, 16'd0);
    rst_n = 1'b1;
    chk_redir("post_rst", 1'b0, 16'h0000);
    chk("post_rst.stall", 32'(stall_front), 32'd0);

    // z-branch taken with valid CC: redirect exactly one cycle later.
    cc_valid = 1'b1; cc = 3'b010; br_valid = 1'b1; br_nzp = 3'b010; br_target = 16'h3000;
    #1 chk("t1.stall", 32'(stall_front), 32'd0);
    cyc(); br_valid = 1'b0;
    chk_redir("t1", 1'b1, 16'h3000);
    chk_cnt("t1", 16'd1, 16'd1);
    cyc();
    chk_redir("t1.end", 1'b0, 16'h0000);

    // Not taken: cc=n, branch on z|p.
    cc = 3'b100; br_valid = 1'b1; br_nzp = 3'b011; br_target = 16'h3100;
    #1 chk("t2.stall", 32'(stall_front), 32'd0);
    cyc(); br_valid = 1'b0;
    chk_redir("t2", 1'b0, 16'h0000);
    chk_cnt("t2", 16'd2, 16'd1);

    // CC unavailable 3 cycles then forwarded: stall 4 cycles, then redirect.
    cc_valid = 1'b0; br_valid = 1'b1; br_nzp = 3'b001; br_target = 16'h4000;
    #1 chk("t3.stall0", 32'(stall_front), 32'd1);
    cyc(); chk("t3.stall1", 32'(stall_front), 32'd1);
    chk("t3.nopc1", 32'(pc_redirect), 32'd0);
    cyc(); chk("t3.stall2", 32'(stall_front), 32'd1);
    cyc(); cc_fwd_valid = 1'b1; cc_fwd = 3'b001;
    #1 chk("t3.stall3", 32'(stall_front), 32'd1);
    cyc(); br_valid = 1'b0; cc_fwd_valid = 1'b0;
    #1 chk("t3.stall4", 32'(stall_front), 32'd0);
    chk_redir("t3", 1'b1, 16'h4000);
    chk_cnt("t3", 16'd3, 16'd2);
    cyc(); chk_redir("t3.end", 1'b0, 16'h0000);

    // Unconditional branch with no CC; redirect held through 2 stall cycles.
    br_valid = 1'b1; br_nzp = 3'b111; br_target = 16'h5000;
    #1 chk("t4.stall", 32'(stall_front), 32'd0);
    cyc(); br_valid = 1'b0; mem_stall = 1'b1;
    chk_redir("t4.c1", 1'b1, 16'h5000);
    cyc(); chk_redir("t4.c2", 1'b1, 16'h5000);
    cyc(); mem_stall = 1'b0;
    chk_redir("t4.c3", 1'b1, 16'h5000);
    cyc(); chk_redir("t4.end", 1'b0, 16'h0000);
    chk_cnt("t4", 16'd4, 16'd3);

    // nzp=000 never taken even with CC available.
    cc_valid = 1'b1; cc = 3'b010; br_valid = 1'b1; br_nzp = 3'b000; br_target = 16'h5100;
    cyc(); br_valid = 1'b0;
    chk_redir("t5", 1'b0, 16'h0000);
    chk_cnt("t5", 16'd5, 16'd3);

    // br_valid ignored while mem_stall in IDLE.
    mem_stall = 1'b1; br_valid = 1'b1; br_nzp = 3'b111; br_target = 16'h5200;
    #1 chk("t6.stall", 32'(stall_front), 32'd0);
    cyc(); cyc();
    chk_redir("t6", 1'b0, 16'h0000);
    chk_cnt("t6", 16'd5, 16'd3);
    mem_stall = 1'b0; br_valid = 1'b0;

    // WAIT_CC resolution delayed by mem_stall, resolves not taken.
    cc_valid = 1'b0; br_valid = 1'b1; br_nzp = 3'b100; br_target = 16'h5300;
    #1 chk("t7.stall0", 32'(stall_front), 32'd1);
    cyc(); br_valid = 1'b0; cc_valid = 1'b1; cc = 3'b001; mem_stall = 1'b1;
    #1 chk("t7.stall1", 32'(stall_front), 32'd1);
    cyc(); chk("t7.stall2", 32'(stall_front), 32'd1);
    chk_cnt("t7.held", 16'd5, 16'd3);
    mem_stall = 1'b0;
    cyc(); chk("t7.stall3", 32'(stall_front), 32'd0);
    chk_redir("t7", 1'b0, 16'h0000);
    chk_cnt("t7", 16'd6, 16'd3);

    // Reset clears counters.
    rst_n = 1'b0;
    cyc(); rst_n = 1'b1;
    chk_cnt("t8", 16'd0, 16'd0);

    // 65535 taken branches saturate both counters; one more leaves them.
    br_valid = 1'b1; br_nzp = 3'b111; br_target = 16'h6000;
    repeat (131070) cyc();
    br_valid = 1'b0;
    chk_redir("t9.idle", 1'b0, 16'h0000);
    chk_cnt("t9.full", 16'hFFFF, 16'hFFFF);
    br_valid = 1'b1;
    cyc(); br_valid = 1'b0;
    chk_redir("t9.extra", 1'b1, 16'h6000);
    chk_cnt("t9.sat", 16'hFFFF, 16'hFFFF);
    cyc();

    // Reset while in WAIT_CC: abort with no redirect, counters cleared.
    cc_valid = 1'b0; br_valid = 1'b1; br_nzp = 3'b010; br_target = 16'h7000;
    cyc(); br_valid = 1'b0;
    chk("t10.wait", 32'(stall_front), 32'd1);
    rst_n = 1'b0;
    #1 chk("t10.rst_stall", 32'(stall_front), 32'd0);
    chk_redir("t10.rst", 1'b0, 16'h0000);
    cyc(); rst_n = 1'b1; cc_valid = 1'b1; cc = 3'b010;
    #1 chk("t10.stall", 32'(stall_front), 32'd0);
    chk_redir("t10.a", 1'b0, 16'h0000);
    chk_cnt("t10", 16'd0, 16'd0);
    cyc();
    chk_redir("t10.b", 1'b0, 16'h0000);
    chk_cnt("t10.b", 16'd0, 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/branch_ctrl.md
BRANCH_CTRL -- requirements
Module: branch_ctrl

Interface
REQ-001 SHALL: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL: rst_n  input  1  synchronous, active-low reset, sampled on rising clk.
REQ-003 SHALL: br_valid  input  1  BR instruction present in resolve stage this cycle.
REQ-004 SHALL: br_nzp  input  3  branch nzp field; bit2=n, bit1=z, bit0=p.
REQ-005 SHALL: br_target  input  16  branch target address.
REQ-006 SHALL: cc_valid  input  1  architectural CC register holds final value; no CC writer in flight.
REQ-007 SHALL: cc  input  3  architectural condition codes (n,z,p).
REQ-008 SHALL: cc_fwd_valid  input  1  in-flight producer delivers final CC this cycle.
REQ-009 SHALL: cc_fwd  input  3  forwarded condition codes.
REQ-010 SHALL: mem_stall  input  1  pipeline frozen by memory stage.
REQ-011 SHALL: stall_front  output  1  hold fetch/decode/resolve stages.
REQ-012 SHALL: pc_redirect  output  1  load PC from redirect_pc.
REQ-013 SHALL: redirect_pc  output  16  taken-branch target.
REQ-014 SHALL: flush_if, flush_id  output  1 each  squash IF and ID pipeline registers.
REQ-015 SHALL: br_count, taken_count  output  16 each  resolved and taken branch counters.

Function
REQ-016 SHALL implement FSM states IDLE, WAIT_CC, REDIRECT; reset state IDLE.
REQ-017 SHALL select CC source: cc_fwd if cc_fwd_valid, else cc if cc_valid, else unavailable.
REQ-018 SHALL compute taken = (br_nzp==3'b111) OR |(br_nzp & CC source); br_nzp==3'b000 never taken.
REQ-019 SHALL treat br_nzp==3'b111 as resolvable regardless of CC availability.
REQ-020 SHALL, in IDLE with br_valid=1 and mem_stall=0: resolvable and taken -> latch br_target, go REDIRECT; resolvable and not taken -> stay IDLE; unresolvable -> latch br_nzp/br_target, go WAIT_CC.
REQ-021 SHALL ignore br_valid while mem_stall=1 in IDLE (no latch, no count).
REQ-022 SHALL, in WAIT_CC, evaluate latched br_nzp when CC source becomes available and mem_stall=0: taken -> REDIRECT; not taken -> IDLE; else remain.
REQ-023 SHALL drive stall_front=1 in WAIT_CC, and combinationally in IDLE when br_valid=1, mem_stall=0 and branch unresolvable.
REQ-024 SHALL drive pc_redirect=flush_if=flush_id=1 only in REDIRECT; redirect_pc=latched target (0 when not in REDIRECT).
REQ-025 SHALL hold REDIRECT while mem_stall=1; leave to IDLE on first cycle with mem_stall=0 (redirect pulse length = 1 + stalled cycles).
REQ-026 SHALL ignore br_valid in REDIRECT and WAIT_CC (instruction is squashed or held).
REQ-027 SHALL increment br_count once per resolution (REQ-020/022 decision), taken_count once per taken resolution, same edge as state transition.
REQ-028 SHALL saturate both counters at 16'hFFFF; no wrap.
REQ-029 SHALL give branch-to-redirect latency of exactly 1 cycle when CC available at acceptance (accept cycle N, pc_redirect high cycle N+1).

Reset
REQ-030 SHALL, on rising clk with rst_n=0 from any state, enter IDLE and clear latched nzp/target and both counters.
REQ-031 SHALL hold all outputs 0 during and in the cycle after reset; rst_n low mid-WAIT_CC or mid-REDIRECT aborts with no redirect.

Verification
REQ-032 SHALL cover: cc=3'b010, cc_valid=1, br_nzp=3'b010, target=16'h3000 -> cycle N+1 pc_redirect=1, redirect_pc=16'h3000, flush_if/id=1 one cycle; br_count=1, taken_count=1.
REQ-033 SHALL cover: cc=3'b100, br_nzp=3'b011 -> no redirect, stall_front=0, br_count=1, taken_count=0.
REQ-034 SHALL cover: cc_valid=0 for 3 cycles, then cc_fwd_valid=1, cc_fwd=3'b001, br_nzp=3'b001 -> stall_front=1 for 4 cycles, redirect next cycle.
REQ-035 SHALL cover: br_nzp=3'b111, cc_valid=0 -> immediate redirect, no stall; REDIRECT with mem_stall=1 for 2 cycles -> pc_redirect high 3 cycles.
REQ-036 SHALL cover: taken_count preloaded to 16'hFFFF via 65535 taken branches -> further taken branch leaves 16'hFFFF; rst_n=0 in WAIT_CC -> IDLE, counters 0, no redirect.
